// File: rtl/stream_avg8_pkg.sv
// Shared types and constants for the streaming 8-sample averager.
package stream_avg8_pkg;

    typedef enum logic [2:0] {
        ACC = 3'd0,
        SH0 = 3'd1,
        SH1 = 3'd2,
        SH2 = 3'd3,
        OUT = 3'd4
    } state_e;

    localparam int NSAMP          = 8;
    localparam int DEF_DATAWIDTH  = 16;
    localparam int DEF_ACCWIDTH   = 32;

endpackage

// File: rtl/stream_avg8_dp.sv
// Accumulator, per-frame shifter and output register for stream_avg8.
// Optional output saturation enabled by defining STREAM_AVG_SAT_EN.
module stream_avg8_dp #(
    parameter int DATAWIDTH = 16,
    parameter int ACCWIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 add,
    input  logic                 shift,
    input  logic                 capture,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic [7:0]           sa,
    output logic [DATAWIDTH-1:0] out_data
);

    logic [ACCWIDTH-1:0]  acc_q, acc_d;
    logic [7:0]           sa_lat_q, sa_lat_d;
    logic [DATAWIDTH-1:0] out_data_q, out_data_d;

    // Shift amounts at or beyond the accumulator width flush it to zero.
    function automatic logic [ACCWIDTH-1:0] shr(input logic [ACCWIDTH-1:0] v,
                                                input logic [7:0] s);
        if (int'(s) >= ACCWIDTH)
            return '0;
        return v >> s;
    endfunction

    function automatic logic [DATAWIDTH-1:0] fit(input logic [ACCWIDTH-1:0] v);
`ifdef STREAM_AVG_SAT_EN
        if (|v[ACCWIDTH-1:DATAWIDTH])
            return '1;
`endif
        return v[DATAWIDTH-1:0];
    endfunction

    always_comb begin
        acc_d      = acc_q;
        sa_lat_d   = sa_lat_q;
        out_data_d = out_data_q;
        if (load) begin
            acc_d    = ACCWIDTH'(in_data);
            sa_lat_d = sa;
        end else if (add) begin
            acc_d = acc_q + ACCWIDTH'(in_data);
        end else if (shift) begin
            acc_d = shr(acc_q, sa_lat_q);
        end
        if (capture)
            out_data_d = fit(acc_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            sa_lat_q   <= '0;
            out_data_q <= '0;
        end else begin
            acc_q      <= acc_d;
            sa_lat_q   <= sa_lat_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

endmodule

// File: rtl/stream_avg8.sv
// Streaming 8-sample averager: accumulate, shift three times by sa, hand off result.
// Output saturation is selected at build time with STREAM_AVG_SAT_EN.
module stream_avg8
    import stream_avg8_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int ACCWIDTH  = DEF_ACCWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           sa,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_e     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       out_valid_q, out_valid_d;
    logic       load, add, shift, capture;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        add         = 1'b0;
        shift       = 1'b0;
        capture     = 1'b0;
        case (state_q)
            ACC: begin
                if (in_valid) begin
                    load    = (count_q == 3'd0);
                    add     = (count_q != 3'd0);
                    count_d = count_q + 3'd1;
                    if (count_q == 3'(NSAMP - 1))
                        state_d = SH0;
                end
            end
            SH0: begin
                shift   = 1'b1;
                state_d = SH1;
            end
            SH1: begin
                shift   = 1'b1;
                state_d = SH2;
            end
            SH2: begin
                shift   = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                // First OUT cycle registers the result; valid is raised from then on.
                if (!out_valid_q) begin
                    capture     = 1'b1;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ACC;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = out_valid_q;

    stream_avg8_dp #(
        .DATAWIDTH (DATAWIDTH),
        .ACCWIDTH  (ACCWIDTH)
    ) u_dp (
        .clk      (Clk),
        .rst      (Rst),
        .load     (load),
        .add      (add),
        .shift    (shift),
        .capture  (capture),
        .in_data  (in_data),
        .sa       (sa),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_stream_avg8.sv
// Directed self-checking bench for stream_avg8.
module tb_stream_avg8;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  sa = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    stream_avg8 dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sa        (sa),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 Clk = ~Clk;

    // Offer one sample; returns after the accepting edge (+1) or after a bounded wait.
    task automatic send(input logic [15:0] d, input logic [7:0] s, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        sa       = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = in_ready;
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_out(output int cyc, output bit ok);
        cyc = 0;
        ok  = out_valid;
        while (!ok && cyc < 50) begin
            @(posedge Clk);
            #1;
            cyc++;
            ok = out_valid;
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    endtask

    task automatic test_basic;
        bit ok, all_ok;
        int cyc;
        out_ready = 1'b1;
        all_ok    = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), 8'd1, ok);
            all_ok &= ok;
        end
        in_valid = 1'b0;
        checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL basic_accept timed out"); end
        wait_out(cyc, ok);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", cyc); end
        checks++; if (out_data !== 16'd4) begin errors++; $display("FAIL basic_data got %0d want 4", out_data); end
        @(posedge Clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got %0b want 1", in_ready); end
    endtask

    task automatic test_max_sum;
        bit ok;
        int cyc;
        logic [15:0] exp;
`ifdef STREAM_AVG_SAT_EN
        exp = 16'hFFFF;
`else
        exp = 16'hFFF8;
`endif
        for (int i = 0; i < 8; i++) send(16'hFFFF, 8'd0, ok);
        in_valid = 1'b0;
        wait_out(cyc, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL max_valid timed out"); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL max_data got %0h want %0h", out_data, exp); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_backpressure;
        bit ok, stable;
        int cyc;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'd100, 8'd1, ok);
        in_valid = 1'b0;
        wait_out(cyc, ok);
        checks++; if (out_data !== 16'd100) begin errors++; $display("FAIL bp_data got %0d want 100", out_data); end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            if (out_data !== 16'd100 || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold data=%0d in_ready=%0b out_valid=%0b want 100/0/1", out_data, in_ready, out_valid); end
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_shift_latch;
        bit ok;
        int cyc;
        for (int i = 0; i < 8; i++) send(16'd64, (i < 3) ? 8'd2 : 8'd7, ok);
        in_valid = 1'b0;
        wait_out(cyc, ok);
        checks++; if (out_data !== 16'd8) begin errors++; $display("FAIL shift_latch got %0d want 8", out_data); end
        @(posedge Clk);
        #1;
        for (int i = 0; i < 8; i++) send(16'd500, (i == 0) ? 8'd40 : 8'd0, ok);
        in_valid = 1'b0;
        wait_out(cyc, ok);
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL shift_wide got %0d want 0", out_data); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_gapped;
        bit ok;
        int cyc;
        int accepts = 0;
        for (int c = 0; c < 300 && accepts < 8; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'd10;
            sa       = 8'd1;
            if (in_valid && in_ready) accepts++;
            @(posedge Clk);
            #1;
        end
        in_valid = 1'b0;
        checks++; if (accepts !== 8) begin errors++; $display("FAIL gap_accepts got %0d want 8", accepts); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL gap_ready_after8 got %0b want 0", in_ready); end
        wait_out(cyc, ok);
        checks++; if (out_data !== 16'd10) begin errors++; $display("FAIL gap_data got %0d want 10", out_data); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int cyc;
        for (int i = 0; i < 5; i++) send(16'd1000, 8'd0, ok);
        in_valid = 1'b0;
        Rst      = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL rstmid_out_data got %0d want 0", out_data); end
        for (int i = 1; i <= 8; i++) send(16'(i), 8'd1, ok);
        in_valid = 1'b0;
        wait_out(cyc, ok);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL rstmid_latency got %0d want 4", cyc); end
        checks++; if (out_data !== 16'd4) begin errors++; $display("FAIL rstmid_data got %0d want 4", out_data); end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_sum();
        test_backpressure();
        test_shift_latch();
        test_gapped();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
